// File: rtl/hazard_scoreboard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_pkg
// Shared definitions for the hazard/scoreboard unit:
//   - default register-address width
//   - forwarding-select encoding used on forwardAE/forwardBE
//   - helper that resolves MEM-over-WB forwarding priority
// -----------------------------------------------------------------------------
package hazard_scoreboard_unit_pkg;

   localparam int unsigned DEF_REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // MEM holds the younger result, so it wins over WB.
   function automatic fwd_sel_e fwd_select(input logic hitMem, input logic hitWb);
      if (hitMem) return FWD_MEM;
      if (hitWb)  return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_if
// Bundle of pipeline-status inputs and hazard-control outputs exchanged
// between the core pipeline (master) and the hazard unit (slave).
//   inputs to unit : per-stage regWrite/memToReg, branch/jump, source and
//                    destination registers, MD issue/completion info
//   outputs of unit: stallF/stallD/flushE, forwarding selects, sbFull,
//                    sbErr, stallCount/flushCount
// -----------------------------------------------------------------------------
interface hazard_scoreboard_unit_if
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_AW = DEF_REG_AW,
   parameter int unsigned CNT_W  = 32
) ();

   logic              regWriteE, regWriteM, regWriteW;
   logic              memToRegE, memToRegM;
   logic              branchD, jumpD;
   logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
   logic [REG_AW-1:0] writeRegE, writeRegM, writeRegW;
   logic              regWriteD;
   logic [REG_AW-1:0] writeRegD;
   logic              mdOpD, mdIssueE, mdDoneW;
   logic [REG_AW-1:0] mdDestW;

   logic              stallF, stallD, flushE;
   logic              forwardAD, forwardBD;
   logic [1:0]        forwardAE, forwardBE;
   logic              sbFull, sbErr;
   logic [CNT_W-1:0]  stallCount, flushCount;

   modport master (
      output regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
             branchD, jumpD, rsD, rtD, rsE, rtE,
             writeRegE, writeRegM, writeRegW, regWriteD, writeRegD,
             mdOpD, mdIssueE, mdDoneW, mdDestW,
      input  stallF, stallD, flushE, forwardAD, forwardBD,
             forwardAE, forwardBE, sbFull, sbErr, stallCount, flushCount
   );

   modport slave (
      input  regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
             branchD, jumpD, rsD, rtD, rsE, rtE,
             writeRegE, writeRegM, writeRegW, regWriteD, writeRegD,
             mdOpD, mdIssueE, mdDoneW, mdDestW,
      output stallF, stallD, flushE, forwardAD, forwardBD,
             forwardAE, forwardBE, sbFull, sbErr, stallCount, flushCount
   );

endinterface

// File: rtl/hazard_scoreboard_unit_md_scoreboard.sv
// -----------------------------------------------------------------------------
// md_scoreboard
// Tracks destination registers of outstanding multiply/divide operations.
//   clk, rst      : clock, synchronous active-high reset
//   i_alloc       : MD op dispatched this cycle, destination i_allocReg
//   i_done        : MD result written back this cycle, destination i_doneReg
//   i_rdReg[2:0]  : three lookup ports (rs, rt, decode destination)
//   o_busy[2:0]   : register on the matching lookup port is pending
//   o_validCount  : number of occupied slots
//   o_freeNow     : completion this cycle hits an occupied slot
//   o_full        : every slot occupied
//   o_err         : sticky protocol error (orphan completion / overflow)
// -----------------------------------------------------------------------------
module md_scoreboard
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_AW  = DEF_REG_AW,
   parameter int unsigned MAX_OUT = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_alloc,
   input  logic [REG_AW-1:0]                i_allocReg,
   input  logic                             i_done,
   input  logic [REG_AW-1:0]                i_doneReg,
   input  logic [2:0][REG_AW-1:0]           i_rdReg,
   output logic [2:0]                       o_busy,
   output logic [$clog2(MAX_OUT+1)-1:0]     o_validCount,
   output logic                             o_freeNow,
   output logic                             o_full,
   output logic                             o_err
);

   localparam int unsigned CW = $clog2(MAX_OUT + 1);

   logic [MAX_OUT-1:0] r_valid;
   logic [REG_AW-1:0]  r_tag [MAX_OUT];
   logic               r_err;

   logic [MAX_OUT-1:0] w_doneHit;
   logic [MAX_OUT-1:0] w_freeSel;
   logic [MAX_OUT-1:0] w_allocSel;
   logic               w_freeFound, w_allocFound;
   logic               w_doneReq, w_allocReq;
   logic [CW-1:0]      w_validCount;
   logic [2:0]         w_hold;

   always_comb begin
      w_doneReq    = i_done && (i_doneReg != '0);
      w_allocReq   = i_alloc && (i_allocReg != '0);
      w_doneHit    = '0;
      w_freeSel    = '0;
      w_allocSel   = '0;
      w_freeFound  = 1'b0;
      w_allocFound = 1'b0;
      w_validCount = '0;

      for (int unsigned i = 0; i < MAX_OUT; i++) begin
         w_doneHit[i] = w_doneReq && r_valid[i] && (r_tag[i] == i_doneReg);
         w_validCount = w_validCount + CW'(r_valid[i]);
      end

      // Only one slot is retired per completion, even if a tag is duplicated.
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
         if (w_doneHit[i] && !w_freeFound) begin
            w_freeSel[i] = 1'b1;
            w_freeFound  = 1'b1;
         end
      end

      // A slot being retired this cycle is reusable by a same-cycle allocation.
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
         if ((!r_valid[i] || w_freeSel[i]) && !w_allocFound) begin
            w_allocSel[i] = 1'b1;
            w_allocFound  = 1'b1;
         end
      end
   end

   // Completion releases the register in the same cycle since the register
   // file is written in the first half of the cycle.
   always_comb begin
      o_busy = '0;
      w_hold = '0;
      for (int unsigned p = 0; p < 3; p++) begin
         for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (r_valid[i] && (r_tag[i] == i_rdReg[p])) w_hold[p] = 1'b1;
         end
         o_busy[p] = (i_rdReg[p] != '0) &&
                     ((w_hold[p] && !(i_done && (i_doneReg == i_rdReg[p]))) ||
                      (i_alloc && (i_allocReg == i_rdReg[p])));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_err   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (w_freeSel[i]) r_valid[i] <= 1'b0;
            if (w_allocReq && w_allocSel[i]) begin
               r_valid[i] <= 1'b1;
               r_tag[i]   <= i_allocReg;
            end
         end
         if ((w_doneReq && !w_freeFound) || (w_allocReq && !w_allocFound))
            r_err <= 1'b1;
      end
   end

   assign o_validCount = w_validCount;
   assign o_freeNow    = |w_doneHit;
   assign o_full       = &r_valid;
   assign o_err        = r_err;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Pipeline hazard unit for the five-stage core plus a multi-cycle MD unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_scoreboard_unit_if.slave
//              in : stage regWrite/memToReg, branch/jump, rs/rt/dest regs,
//                   MD issue and completion
//              out: stallF/stallD/flushE, forwardAD/BD, forwardAE/BE,
//                   sbFull, sbErr, saturating stallCount/flushCount
// Stall, forwarding and counters live here; MD tracking is in md_scoreboard.
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int unsigned REG_AW  = DEF_REG_AW,
   parameter int unsigned MAX_OUT = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   hazard_scoreboard_unit_if.slave    bus
);

   localparam int unsigned CW = $clog2(MAX_OUT + 1);
   localparam int unsigned PW = CW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0]       w_busy;
   logic [CW-1:0]    w_validCount;
   logic             w_freeNow;
   logic             w_sbFull, w_sbErr;
   logic [PW-1:0]    w_pending;
   logic             w_lwStall, w_brStall, w_sbStall;
   logic             w_stall, w_flush;
   logic [CNT_W-1:0] r_stallCount, r_flushCount;

   md_scoreboard #(
      .REG_AW  (REG_AW),
      .MAX_OUT (MAX_OUT)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .i_alloc      (bus.mdIssueE),
      .i_allocReg   (bus.writeRegE),
      .i_done       (bus.mdDoneW),
      .i_doneReg    (bus.mdDestW),
      .i_rdReg      ({bus.writeRegD, bus.rtD, bus.rsD}),
      .o_busy       (w_busy),
      .o_validCount (w_validCount),
      .o_freeNow    (w_freeNow),
      .o_full       (w_sbFull),
      .o_err        (w_sbErr)
   );

   // Occupancy the decode-stage MD op would see once this cycle's issue and
   // completion have landed; never underflows because freeNow implies a valid slot.
   assign w_pending = {1'b0, w_validCount} + PW'(bus.mdIssueE) - PW'(w_freeNow);

   assign w_lwStall = bus.memToRegE && ((bus.rsD == bus.rtE) || (bus.rtD == bus.rtE));

   assign w_brStall = bus.branchD &&
      ((bus.regWriteE && ((bus.writeRegE == bus.rsD) || (bus.writeRegE == bus.rtD))) ||
       (bus.memToRegM && ((bus.writeRegM == bus.rsD) || (bus.writeRegM == bus.rtD))));

   // busy[2] is the WAW check on the decode destination.
   assign w_sbStall = w_busy[0] || w_busy[1] || (bus.regWriteD && w_busy[2]) ||
                      (bus.mdOpD && (w_pending >= PW'(MAX_OUT)));

   assign w_stall = w_lwStall || w_brStall || w_sbStall;
   assign w_flush = w_stall || bus.jumpD;

   assign bus.stallF = w_stall;
   assign bus.stallD = w_stall;
   assign bus.flushE = w_flush;

   assign bus.forwardAD = (bus.rsD != '0) && (bus.rsD == bus.writeRegM) && bus.regWriteM;
   assign bus.forwardBD = (bus.rtD != '0) && (bus.rtD == bus.writeRegM) && bus.regWriteM;

   assign bus.forwardAE = fwd_select(
      (bus.rsE != '0) && (bus.rsE == bus.writeRegM) && bus.regWriteM,
      (bus.rsE != '0) && (bus.rsE == bus.writeRegW) && bus.regWriteW);
   assign bus.forwardBE = fwd_select(
      (bus.rtE != '0) && (bus.rtE == bus.writeRegM) && bus.regWriteM,
      (bus.rtE != '0) && (bus.rtE == bus.writeRegW) && bus.regWriteW);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else begin
         if (w_stall && (r_stallCount != CNT_MAX)) r_stallCount <= r_stallCount + CNT_W'(1);
         if (w_flush && (r_flushCount != CNT_MAX)) r_flushCount <= r_flushCount + CNT_W'(1);
      end
   end

   assign bus.sbFull     = w_sbFull;
   assign bus.sbErr      = w_sbErr;
   assign bus.stallCount = r_stallCount;
   assign bus.flushCount = r_flushCount;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Directed scenarios followed by random stimulus. The driver computes the
// expected outputs from a behavioural model (outstanding MD destinations kept
// as a plain list) and queues them; the monitor compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   localparam int unsigned AW   = 5;
   localparam int unsigned MAXO = 2;
   localparam int unsigned CW   = 4;
   localparam int          SAT  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

   hazard_scoreboard_unit #(
      .REG_AW  (AW),
      .MAX_OUT (MAXO),
      .CNT_W   (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          rst;
      logic          regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
      logic          branchD, jumpD, regWriteD, mdOpD, mdIssueE, mdDoneW;
      logic [AW-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
      logic [AW-1:0] writeRegD, mdDestW;
   } stim_t;

   typedef struct {
      logic       stall, flush, fAD, fBD, full, err;
      logic [1:0] fAE, fBE;
      int         sc, fc;
   } exp_t;

   exp_t exp_q[$];
   int   outq[$];          // outstanding MD destinations, oldest first
   bit   m_err = 1'b0;
   int   m_sc  = 0;
   int   m_fc  = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   drv_done = 1'b0;

   function automatic bit m_holds(int r);
      foreach (outq[i]) if (outq[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_busy(stim_t s, int r);
      if (r == 0) return 1'b0;
      return (m_holds(r) && !(s.mdDoneW && int'(s.mdDestW) == r)) ||
             (s.mdIssueE && int'(s.writeRegE) == r);
   endfunction

   function automatic logic [1:0] m_fwd(int src, stim_t s);
      if (src != 0 && src == int'(s.writeRegM) && s.regWriteM) return 2'b10;
      if (src != 0 && src == int'(s.writeRegW) && s.regWriteW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s = idle();
      s.rst       = ($urandom_range(0, 59) == 0);
      s.regWriteE = 1'($urandom_range(0, 1));
      s.regWriteM = 1'($urandom_range(0, 1));
      s.regWriteW = 1'($urandom_range(0, 1));
      s.memToRegE = ($urandom_range(0, 3) == 0);
      s.memToRegM = ($urandom_range(0, 3) == 0);
      s.branchD   = ($urandom_range(0, 3) == 0);
      s.jumpD     = ($urandom_range(0, 7) == 0);
      s.regWriteD = 1'($urandom_range(0, 1));
      s.mdOpD     = ($urandom_range(0, 3) == 0);
      s.mdIssueE  = ($urandom_range(0, 3) == 0);
      s.rsD       = AW'($urandom_range(0, 7));
      s.rtD       = AW'($urandom_range(0, 7));
      s.rsE       = AW'($urandom_range(0, 7));
      s.rtE       = AW'($urandom_range(0, 7));
      s.writeRegE = AW'($urandom_range(0, 7));
      s.writeRegM = AW'($urandom_range(0, 7));
      s.writeRegW = AW'($urandom_range(0, 7));
      s.writeRegD = AW'($urandom_range(0, 7));
      if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
         s.mdDoneW = 1'b1;
         s.mdDestW = AW'(outq[$urandom_range(0, outq.size() - 1)]);
      end else if ($urandom_range(0, 39) == 0) begin
         s.mdDoneW = 1'b1;
         s.mdDestW = AW'($urandom_range(0, 15));
      end
      return s;
   endfunction

   // Drives one cycle of stimulus, queues its expected response and then
   // advances the model to the state after the coming clock edge.
   task automatic apply(input stim_t s);
      exp_t e;
      bit   lw, br, sb, hit;
      int   idx;
      @(posedge clk);
      #1;
      rst           = s.rst;
      bus.regWriteE = s.regWriteE;  bus.regWriteM = s.regWriteM;
      bus.regWriteW = s.regWriteW;  bus.memToRegE = s.memToRegE;
      bus.memToRegM = s.memToRegM;  bus.branchD   = s.branchD;
      bus.jumpD     = s.jumpD;      bus.regWriteD = s.regWriteD;
      bus.mdOpD     = s.mdOpD;      bus.mdIssueE  = s.mdIssueE;
      bus.mdDoneW   = s.mdDoneW;    bus.mdDestW   = s.mdDestW;
      bus.rsD       = s.rsD;        bus.rtD       = s.rtD;
      bus.rsE       = s.rsE;        bus.rtE       = s.rtE;
      bus.writeRegE = s.writeRegE;  bus.writeRegM = s.writeRegM;
      bus.writeRegW = s.writeRegW;  bus.writeRegD = s.writeRegD;

      lw  = s.memToRegE && (s.rsD == s.rtE || s.rtD == s.rtE);
      br  = s.branchD &&
            ((s.regWriteE && (s.writeRegE == s.rsD || s.writeRegE == s.rtD)) ||
             (s.memToRegM && (s.writeRegM == s.rsD || s.writeRegM == s.rtD)));
      hit = s.mdDoneW && m_holds(int'(s.mdDestW));
      sb  = m_busy(s, int'(s.rsD)) || m_busy(s, int'(s.rtD)) ||
            (s.regWriteD && m_busy(s, int'(s.writeRegD))) ||
            (s.mdOpD && (outq.size() + int'(s.mdIssueE) - int'(hit) >= int'(MAXO)));
      e.stall = lw || br || sb;
      e.flush = e.stall || s.jumpD;
      e.fAD   = (s.rsD != 0) && (s.rsD == s.writeRegM) && s.regWriteM;
      e.fBD   = (s.rtD != 0) && (s.rtD == s.writeRegM) && s.regWriteM;
      e.fAE   = m_fwd(int'(s.rsE), s);
      e.fBE   = m_fwd(int'(s.rtE), s);
      e.full  = (outq.size() == int'(MAXO));
      e.err   = m_err;
      e.sc    = m_sc;
      e.fc    = m_fc;
      exp_q.push_back(e);

      if (s.rst) begin
         outq.delete();
         m_err = 1'b0;
         m_sc  = 0;
         m_fc  = 0;
      end else begin
         if (e.stall && m_sc < SAT) m_sc++;
         if (e.flush && m_fc < SAT) m_fc++;
         if (s.mdDoneW && s.mdDestW != 0) begin
            idx = -1;
            foreach (outq[i]) if (idx < 0 && outq[i] == int'(s.mdDestW)) idx = i;
            if (idx >= 0) outq.delete(idx);
            else          m_err = 1'b1;
         end
         if (s.mdIssueE && s.writeRegE != 0) begin
            if (outq.size() < int'(MAXO)) outq.push_back(int'(s.writeRegE));
            else                          m_err = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver
   initial begin
      stim_t s;
      rst = 1'b1;
      bus.regWriteE = 0; bus.regWriteM = 0; bus.regWriteW = 0;
      bus.memToRegE = 0; bus.memToRegM = 0; bus.branchD = 0; bus.jumpD = 0;
      bus.regWriteD = 0; bus.mdOpD = 0; bus.mdIssueE = 0; bus.mdDoneW = 0;
      bus.rsD = 0; bus.rtD = 0; bus.rsE = 0; bus.rtE = 0;
      bus.writeRegE = 0; bus.writeRegM = 0; bus.writeRegW = 0;
      bus.writeRegD = 0; bus.mdDestW = 0;
      repeat (2) @(posedge clk);

      s = idle(); s.rst = 1'b1; apply(s);

      // load-use
      s = idle(); s.memToRegE = 1; s.rtE = 5; s.rsD = 5; apply(s);
      apply(idle());

      // forwarding priority, then register 0 never forwards
      s = idle(); s.rsE = 3; s.writeRegM = 3; s.regWriteM = 1;
      s.writeRegW = 3; s.regWriteW = 1; apply(s);
      s.rsE = 0; apply(s);
      s = idle(); s.rtE = 4; s.writeRegW = 4; s.regWriteW = 1; apply(s);

      // MD RAW on register 8
      s = idle(); s.mdIssueE = 1; s.writeRegE = 8; apply(s);
      s = idle(); s.rsD = 8; repeat (3) apply(s);
      s.mdDoneW = 1; s.mdDestW = 8; apply(s);
      apply(idle());

      // structural stall with both slots busy
      s = idle(); s.mdIssueE = 1; s.writeRegE = 9;  apply(s);
      s.writeRegE = 10; apply(s);
      s = idle(); s.mdOpD = 1; apply(s);
      s.mdDoneW = 1; s.mdDestW = 9; apply(s);
      s = idle(); s.mdDoneW = 1; s.mdDestW = 10; apply(s);

      // orphan completion, sticky error, reset with live entries
      s = idle(); s.mdDoneW = 1; s.mdDestW = 12; apply(s);
      repeat (2) apply(idle());
      s = idle(); s.mdIssueE = 1; s.writeRegE = 9;  apply(s);
      s.writeRegE = 10; apply(s);
      s = idle(); s.mdIssueE = 1; s.writeRegE = 11; apply(s);
      s = idle(); s.rst = 1; apply(s);
      repeat (2) apply(idle());

      // counter saturation
      s = idle(); s.memToRegE = 1; s.rtE = 6; s.rtD = 6;
      repeat (20) apply(s);
      repeat (2) apply(idle());

      repeat (3000) apply(rand_stim());
      drv_done = 1'b1;
   end

   // Monitor
   initial begin
      exp_t e;
      int   cyc;
      cyc = 0;
      while (!(drv_done && exp_q.size() == 0)) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL monitor_timeout: got %0d cycles expected completion", cyc);
            break;
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stallF",     32'(bus.stallF),     32'(e.stall));
            chk("stallD",     32'(bus.stallD),     32'(e.stall));
            chk("flushE",     32'(bus.flushE),     32'(e.flush));
            chk("forwardAD",  32'(bus.forwardAD),  32'(e.fAD));
            chk("forwardBD",  32'(bus.forwardBD),  32'(e.fBD));
            chk("forwardAE",  32'(bus.forwardAE),  32'(e.fAE));
            chk("forwardBE",  32'(bus.forwardBE),  32'(e.fBE));
            chk("sbFull",     32'(bus.sbFull),     32'(e.full));
            chk("sbErr",      32'(bus.sbErr),      32'(e.err));
            chk("stallCount", 32'(bus.stallCount), 32'(e.sc));
            chk("flushCount", 32'(bus.flushCount), 32'(e.fc));
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the pipeline hazard unit. It covers the five-stage core plus a multi-cycle multiply/divide unit (MD). It keeps the existing stall, flush and forwarding rules: load-use stall, branch-compare stall, EX/MEM/WB forwarding and decode-stage branch forwarding. It adds a sequential scoreboard that tracks outstanding MD destination registers, structural stalling when all scoreboard slots are in use, saturating stall/flush performance counters and a sticky protocol-error flag.

Parameters:
REG_AW, 5, register-address width; register 0 is hardwired zero and is never busy or forwarded.
MAX_OUT, 2, number of scoreboard slots (maximum outstanding MD ops), 1..8.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
regWriteE, regWriteM, regWriteW  in  1  normal-path register write enables per stage
memToRegE, memToRegM  in  1  load in EX / MEM
branchD, jumpD  in  1  branch / jump in decode
rsD, rtD, rsE, rtE  in  REG_AW  source registers
writeRegE, writeRegM, writeRegW  in  REG_AW  destination registers
regWriteD  in  1  instruction in decode writes a register
writeRegD  in  REG_AW  destination of the instruction in decode
mdOpD  in  1  instruction in decode is an MD op
mdIssueE  in  1  MD op is in EX this cycle and is dispatched to the MD unit
mdDoneW  in  1  MD result is written to the register file this cycle
mdDestW  in  REG_AW  destination of the completing MD op
stallF, stallD, flushE  out  1  pipeline control
forwardAD, forwardBD  out  1  decode-stage branch operand forwarding from MEM
forwardAE, forwardBE  out  2  EX operand select: 10 = MEM, 01 = WB, 00 = register file
sbFull  out  1  all MAX_OUT slots valid
sbErr  out  1  sticky protocol error
stallCount, flushCount  out  CNT_W  saturating performance counters

Behaviour:
- Outputs are combinational except sbFull, sbErr and the counters. On reset: all scoreboard slots invalid, sbErr=0, both counters=0, so sbFull=0.
- lwStall = memToRegE & (rsD==rtE | rtD==rtE).
- brStall = branchD & ((regWriteE & writeRegE matches rsD/rtD) | (memToRegM & writeRegM matches rsD/rtD)).
- forwardAE/BE: MEM has priority over WB. Forwarding needs a nonzero source, an address match and the stage's regWrite. forwardAD/BD: nonzero source matching writeRegM with regWriteM.
- busy(r) is true when r!=0 and either:
  - a valid slot holds r and not (mdDoneW & mdDestW==r), or
  - mdIssueE & writeRegE==r.
- Completion in the same cycle clears the busy state, because the register file writes in the first half-cycle.
- sbStall = busy(rsD) | busy(rtD) | (regWriteD & busy(writeRegD)) | (mdOpD & (validCount + mdIssueE - freeNow) >= MAX_OUT).
  - The regWriteD term is the WAW check.
  - freeNow = 1 when mdDoneW hits a valid slot, otherwise 0.
- stallF = stallD = lwStall | brStall | sbStall.
- flushE = stallD | jumpD.
- Allocate at the clock edge when mdIssueE & writeRegE!=0: use the lowest-index free slot and store the destination.
- Free at the clock edge the slot whose destination equals mdDestW when mdDoneW. Allocate and free in the same cycle both take effect.
- sbErr is set and held until reset on either condition:
  - mdDoneW with no matching valid slot (mdDestW==0 is ignored and does not set sbErr);
  - allocation requested while no slot is free (the request is dropped).
- Counters: stallCount +1 each cycle stallD=1; flushCount +1 each cycle flushE=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-operation discards all outstanding entries immediately at that edge.

Decomposition:
- Shared header: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the default REG_AW.
- One sub-module, md_scoreboard. It holds the slots plus valid bits, does the lowest-free allocation, frees slots by match, and provides the busy lookup on three read ports, validCount, sbFull and sbErr.
- Stall, forward and counter logic stay in the top level.

Test Plan:
- Load-use: memToRegE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for one cycle; stallCount goes 0->1.
- Forwarding priority: rsE=3, writeRegM=3, regWriteM=1, writeRegW=3, regWriteW=1 -> forwardAE=10. Repeat with rsE=0 -> forwardAE=00.
- MD RAW: mdIssueE with writeRegE=8, then rsD=8 -> stallD=1 each cycle until the cycle mdDoneW=1, mdDestW=8, in which stallD=0.
- Structural stall (MAX_OUT=2): issue MD ops to regs 9 and 10, then mdOpD=1 -> sbFull=1 and stallD=1. Complete reg 9 -> stallD drops in the same cycle.
- Errors: mdDoneW with mdDestW=12 and no slot holding 12 -> sbErr=1 next cycle, holding until rst. Assert rst with 2 slots valid -> sbFull=0 and the counters read 0 after the edge.
- Saturation (CNT_W=4): hold stallD for 20 cycles -> stallCount=15.
